// File: rtl/fadd_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready flow control and a passthrough tag.
// Denormal inputs are flushed to zero and no denormals are produced; NaN results are canonical.
module fadd_pipe #(
   parameter int EW    = 8,
   parameter int MW    = 23,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EW+MW:0]   x1,
   input  logic [EW+MW:0]   x2,
   input  logic             sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EW+MW:0]   y,
   output logic [TAG_W-1:0] out_tag
);
   localparam int W   = 1 + EW + MW;
   localparam int FW  = MW + 4;
   localparam int LZW = $clog2(FW + 1);
   localparam int XW  = (EW + 2 > LZW + 1) ? EW + 2 : LZW + 1;
   localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
   localparam logic signed [XW-1:0] EMAX  = XW'((2 ** EW) - 1);
   localparam logic signed [XW-1:0] EZERO = '0;

   function automatic logic f_round_up(input logic lsb, input logic g, input logic r,
                                       input logic s);
      return g & (r | s | lsb);
   endfunction

   function automatic logic [LZW-1:0] f_lzc(input logic [FW-1:0] v);
      logic [LZW-1:0] n;
      n = LZW'(FW);
      for (int i = 0; i < FW; i++) begin
         if (v[i]) n = LZW'(FW - 1 - i);
      end
      return n;
   endfunction

   logic                 r_vld_p1, r_vld_p2, r_vld_p3;
   logic [TAG_W-1:0]     r_tag_p1, r_tag_p2, r_tag_p3;
   logic                 r_spec_p1, r_spec_p2;
   logic [W-1:0]         r_spec_y_p1, r_spec_y_p2, r_y_p3;
   logic                 r_sign_p1, r_sign_p2;
   logic                 r_esub_p1;
   logic [EW-1:0]        r_exp_p1;
   logic [FW-1:0]        r_fa_p1, r_fb_p1, r_mant_p2;
   logic signed [XW-1:0] r_exp_p2;
   logic [LZW-1:0]       r_lz_p2;
   logic                 r_zero_p2;

   assign in_ready  = !r_vld_p3 || out_ready;
   assign out_valid = r_vld_p3;
   assign y         = r_y_p3;
   assign out_tag   = r_tag_p3;

   // ---- stage 1: unpack, special detection, swap, align with sticky
   logic          w_s1, w_s2;
   logic [EW-1:0] w_e1, w_e2, w_ea, w_eb, w_diff;
   logic [MW-1:0] w_m1, w_m2, w_ma, w_mb;
   logic          w_x1_big, w_spec;
   logic [W-1:0]  w_spec_y;
   logic [FW-1:0] w_fa, w_fb, w_fb_al;
   logic [31:0]   w_sh;
   logic [2*FW-1:0] w_wide;

   assign w_s1 = x1[W-1];
   assign w_e1 = x1[W-2:MW];
   assign w_m1 = x1[MW-1:0];
   assign w_s2 = x2[W-1] ^ sub;
   assign w_e2 = x2[W-2:MW];
   assign w_m2 = x2[MW-1:0];

   assign w_x1_big = (w_e1 > w_e2) || ((w_e1 == w_e2) && (w_m1 >= w_m2));
   assign w_ea     = w_x1_big ? w_e1 : w_e2;
   assign w_eb     = w_x1_big ? w_e2 : w_e1;
   assign w_ma     = w_x1_big ? w_m1 : w_m2;
   assign w_mb     = w_x1_big ? w_m2 : w_m1;
   assign w_diff   = w_ea - w_eb;
   assign w_fa     = {|w_ea, w_ma, 3'b000};
   assign w_fb     = {|w_eb, w_mb, 3'b000};
   assign w_sh     = (32'(w_diff) > 32'(MW + 3)) ? 32'(MW + 3) : 32'(w_diff);
   assign w_wide   = {w_fb, {FW{1'b0}}} >> w_sh;
   assign w_fb_al  = {w_wide[2*FW-1:FW+1], w_wide[FW] | (|w_wide[FW-1:0])};

   always_comb begin
      w_spec   = 1'b1;
      w_spec_y = '0;
      if (((&w_e1) && (|w_m1)) || ((&w_e2) && (|w_m2)))
         w_spec_y = QNAN;
      else if ((&w_e1) && (&w_e2) && (w_s1 != w_s2))
         w_spec_y = QNAN;
      else if (&w_e1)
         w_spec_y = x1;
      else if ((&w_e2) || (w_e1 == '0))
         w_spec_y = {w_s2, w_e2, w_m2};
      else if (w_e2 == '0)
         w_spec_y = x1;
      else
         w_spec = 1'b0;
   end

   // ---- stage 2: add/subtract magnitudes, carry normalise, leading-zero count
   logic [FW:0]          w_sum;
   logic [FW-1:0]        w_sum_n;
   logic signed [XW-1:0] w_exp_n;

   assign w_sum   = r_esub_p1 ? ({1'b0, r_fa_p1} - {1'b0, r_fb_p1})
                              : ({1'b0, r_fa_p1} + {1'b0, r_fb_p1});
   assign w_sum_n = w_sum[FW] ? {w_sum[FW:2], w_sum[1] | w_sum[0]} : w_sum[FW-1:0];
   assign w_exp_n = $signed(XW'(r_exp_p1)) + $signed(XW'(w_sum[FW]));

   // ---- stage 3: normalise, round to nearest even, exponent range and special select
   logic [FW-2:0]        w_norm;
   logic                 w_rnd;
   logic [MW:0]          w_mr;
   logic signed [XW-1:0] w_exp_f;
   logic [W-1:0]         w_y;

   assign w_norm  = (FW-1)'(r_mant_p2 << r_lz_p2);
   assign w_rnd   = f_round_up(w_norm[3], w_norm[2], w_norm[1], w_norm[0]);
   assign w_mr    = {1'b0, w_norm[FW-2:3]} + {{MW{1'b0}}, w_rnd};
   assign w_exp_f = r_exp_p2 - $signed(XW'(r_lz_p2)) + $signed(XW'(w_mr[MW]));

   always_comb begin
      w_y = {r_sign_p2, w_exp_f[EW-1:0], w_mr[MW-1:0]};
      if (r_spec_p2)
         w_y = r_spec_y_p2;
      else if (r_zero_p2)
         w_y = '0;
      else if (w_exp_f <= EZERO)
         w_y = {r_sign_p2, {(W-1){1'b0}}};
      else if (w_exp_f >= EMAX)
         w_y = {r_sign_p2, {EW{1'b1}}, {MW{1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (in_ready) begin
         r_tag_p1    <= in_tag;
         r_spec_p1   <= w_spec;
         r_spec_y_p1 <= w_spec_y;
         r_sign_p1   <= w_x1_big ? w_s1 : w_s2;
         r_esub_p1   <= w_s1 ^ w_s2;
         r_exp_p1    <= w_ea;
         r_fa_p1     <= w_fa;
         r_fb_p1     <= w_fb_al;
         r_tag_p2    <= r_tag_p1;
         r_spec_p2   <= r_spec_p1;
         r_spec_y_p2 <= r_spec_y_p1;
         r_sign_p2   <= r_sign_p1;
         r_exp_p2    <= w_exp_n;
         r_mant_p2   <= w_sum_n;
         r_lz_p2     <= f_lzc(w_sum_n);
         r_zero_p2   <= (w_sum == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_vld_p3 <= 1'b0;
         r_y_p3   <= '0;
         r_tag_p3 <= '0;
      end else if (in_ready) begin
         r_vld_p1 <= in_valid;
         r_vld_p2 <= r_vld_p1;
         r_vld_p3 <= r_vld_p2;
         r_y_p3   <= w_y;
         r_tag_p3 <= r_tag_p2;
      end
   end
endmodule
